// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw bus, deframes 11-bit frames,
// tracks E0/F0 prefixes and emits one 9-bit key event per make/break code.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [8:0] key_code,
    output logic       key_make,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [1:0]    clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic          filt_q, filt_d, fall_q, fall_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d, stop_q, stop_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          key_valid_q, key_valid_d, key_make_q, key_make_d;
    logic          frame_err_q, frame_err_d;
    logic [8:0]    key_code_q, key_code_d;
    logic          data_s;

    assign data_s = data_sync_q[1];

    // Synchronizers and clock glitch filter; fall is a registered 1->0 strobe
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        fcnt_d      = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    // Deframing FSM, prefix tracking and registered event outputs
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        stop_d      = stop_q;
        tcnt_d      = '0;
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
        key_code_d  = key_code_q;
        key_make_d  = key_make_q;
        case (state_q)
            IDLE: begin
                // a fall with data high is line noise, not a start bit
                if (fall_q && !data_s) begin
                    state_d  = RECV;
                    bitcnt_d = '0;
                end
            end
            RECV: begin
                if (fall_q) begin
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q < 4'd8) begin
                        shift_d = {data_s, shift_q[7:1]};   // LSB arrives first
                    end else if (bitcnt_q == 4'd8) begin
                        par_d = data_s;
                    end else begin
                        stop_d  = data_s;
                        state_d = CHECK;
                    end
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if ((^{shift_q, par_q}) && stop_q) begin
                    if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        key_code_d  = {ext_q, shift_q};
                        key_make_d  = ~brk_q;
                        key_valid_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; bus conditioning resets to idle-high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            fall_q      <= 1'b0;
            fcnt_q      <= '0;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
            tcnt_q      <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_make_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            fall_q      <= fall_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            tcnt_q      <= tcnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_make_q  <= key_make_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_make  = key_make_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames and compares the observed
// event stream against a byte-level reference model.
module tb_ps2_key_decoder;
    localparam int HALF = 20;

    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic       key_valid, key_make, frame_err;
    logic [8:0] key_code;

    int vecs = 0, errs = 0;
    logic [10:0] exp_q[$], obs_q[$];   // {is_err, make, code}
    bit          m_ext = 1'b0, m_brk = 1'b0;
    logic [8:0]  last_code = '0;
    bit          have_key = 1'b0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(2000), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_valid(key_valid), .key_code(key_code), .key_make(key_make),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Record every output pulse; a stretched pulse shows up as a duplicate
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) obs_q.push_back({1'b0, key_make, key_code});
            if (frame_err) obs_q.push_back({1'b1, 10'h000});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Reference model: one call per complete byte frame
    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            exp_q.push_back({1'b1, 10'h000});
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            exp_q.push_back({1'b0, ~m_brk, m_ext, b});
            last_code = {m_ext, b};
            have_key  = 1;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            ps2_data = f[i];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad);
        send_bits(b, bad, 11);
        wait_clk(60);
        model_byte(b, bad);
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, "_cnt"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
        if (have_key) chk({tag, "_hold"}, key_code, last_code);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        bit         bad;
        int         r;

        wait_clk(3);
        @(negedge clk);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_make", key_make, 0);
        chk("rst_err", frame_err, 0);
        rst = 1'b0;
        wait_clk(10);

        frame(8'h1C, 0);                              check_events("make_1c");
        frame(8'hF0, 0); frame(8'h1C, 0);             check_events("break_1c");
        frame(8'hE0, 0); frame(8'h74, 0);             check_events("ext_make");
        frame(8'hE0, 0); frame(8'hF0, 0); frame(8'h74, 0); check_events("ext_break");
        frame(8'hE0, 0); frame(8'h1C, 1);             check_events("bad_par");
        frame(8'h1C, 0);                              check_events("after_err");
        frame(8'hE1, 0);                              check_events("e1_plain");

        // timeout: no error early, one error after the silence, flags dropped
        frame(8'hE0, 0);
        send_bits(8'h29, 0, 5);
        wait_clk(1900);
        check_events("to_early");
        wait_clk(1100);
        exp_q.push_back({1'b1, 10'h000});
        m_ext = 0; m_brk = 0;
        check_events("timeout");
        frame(8'h29, 0);                              check_events("after_to");

        // short glitch while idle must be invisible
        @(posedge clk); ps2_clk = 1'b0;
        wait_clk(2);    ps2_clk = 1'b1;
        wait_clk(40);
        check_events("glitch");
        frame(8'h1C, 0);                              check_events("post_glitch");

        // reset mid-frame clears everything, including a pending E0
        frame(8'hE0, 0);
        send_bits(8'h5A, 0, 5);
        @(posedge clk); rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_make", key_make, 0);
        chk("mid_rst_err", frame_err, 0);
        wait_clk(3);
        rst = 1'b0;
        m_ext = 0; m_brk = 0; have_key = 0;
        obs_q.delete(); exp_q.delete();
        wait_clk(10);
        frame(8'h5A, 0);                              check_events("post_rst");

        // randomized byte stream with prefixes and occasional parity errors
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hE0;
            else if (r < 4)  b = 8'hF0;
            else if (r == 4) b = 8'hE1;
            else             b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            frame(b, bad);
            check_events("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
